// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
// Buffer entries are packed as {err, parcel[15:0]}.
package fetch_pkg;

  localparam int unsigned ParcelW = 16;
  localparam int unsigned EntryW  = ParcelW + 1;
  localparam int unsigned ErrBit  = ParcelW;

  // An all-zero parcel decodes as an illegal instruction, so bus errors surface as traps.
  localparam logic [ParcelW-1:0] TrapParcel = 16'h0000;

  typedef enum logic [0:0] {
    StReset,
    StRun
  } fetch_state_e;

  function automatic logic [EntryW-1:0] make_entry(input logic err,
                                                   input logic [ParcelW-1:0] parcel);
    return {err, err ? TrapParcel : parcel};
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Parcel prefetch FIFO: up to two pushes (low parcel first) and one pop per cycle.
module ifetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_lo,
  input  logic                     push_hi,
  input  logic [EntryW-1:0]        din_lo,
  input  logic [EntryW-1:0]        din_hi,
  input  logic                     pop,
  output logic [EntryW-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [EntryW-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     hi_ptr;

  // The high parcel lands behind the low one, or at the write pointer when the low half is skipped.
  assign hi_ptr = wr_ptr + AW'(push_lo);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_lo) mem[wr_ptr] <= din_lo;
      if (push_hi) mem[hi_ptr] <= din_hi;
      wr_ptr <= wr_ptr + AW'(push_lo) + AW'(push_hi);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_lo) + CW'(push_hi) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (32'(count) + 32'(push_lo) + 32'(push_hi) <= DEPTH + 32'(pop));
      assert (!pop || count != '0);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues word reads, splits responses into 16-bit parcels and
// hands one parcel per cycle to decode, with redirect and in-flight discard handling.
module ifetch
  import fetch_pkg::*;
#(
  parameter int unsigned   RV       = 32,
  parameter logic [RV-1:0] RESET_PC = '0,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   MAX_OUT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ParcelW-1:0] ins,
  output logic [RV-1:0]      ins_pc,
  output logic               ins_err,
  output logic               idone,
  input  logic               stall,
  input  logic               redirect,
  input  logic [RV-1:0]      redirect_pc,
  output logic               i_req,
  output logic [RV-1:0]      i_addr,
  input  logic               i_ack,
  input  logic               i_rvalid,
  input  logic [31:0]        i_rdata,
  input  logic               i_err
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1) + 1;

  fetch_state_e          state;
  logic [RV-1:0]         fetch_pc;
  logic [RV-1:0]         head_pc;
  logic                  skip_low;
  logic [OutW-1:0]       outstanding;
  logic [OutW-1:0]       discard;
  logic [OutW-1:0]       outstanding_next;
  logic [$clog2(DEPTH):0] count;
  logic [EntryW-1:0]     head;

  logic run;
  logic redir;
  logic ack_in;
  logic rvalid_in;
  logic accept;
  logic push_lo;
  logic push_hi;

  assign run       = (state == StRun);
  assign redir     = run && redirect;
  assign rvalid_in = run && i_rvalid;
  // An ack seen during a redirect still creates a response we must later drop.
  assign ack_in    = i_ack && (i_req || redir);
  assign accept    = rvalid_in && !redir && (discard == '0);
  assign push_lo   = accept && !skip_low;
  assign push_hi   = accept;

  assign outstanding_next = outstanding + OutW'(ack_in) - OutW'(rvalid_in);

  // Reserve room for every in-flight word plus the one being requested.
  assign i_req  = run && !redirect && (32'(outstanding) < MAX_OUT) &&
                  (32'(count) + 2 * (32'(outstanding) + 1) <= DEPTH);
  assign i_addr = fetch_pc & ~RV'(3);

  assign idone   = run && (count != '0) && !stall && !redirect;
  assign ins     = (count != '0) ? head[ParcelW-1:0] : '0;
  assign ins_err = (count != '0) && head[ErrBit];
  assign ins_pc  = head_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StReset;
      fetch_pc    <= RESET_PC & ~RV'(3);
      head_pc     <= RESET_PC & ~RV'(1);
      skip_low    <= RESET_PC[1];
      outstanding <= '0;
      discard     <= '0;
    end else begin
      unique case (state)
        StReset: state <= StRun;
        StRun:   state <= StRun;
        default: state <= StReset;
      endcase
      outstanding <= outstanding_next;
      if (redir) begin
        fetch_pc <= redirect_pc & ~RV'(3);
        head_pc  <= redirect_pc & ~RV'(1);
        skip_low <= redirect_pc[1];
        discard  <= outstanding_next;
      end else begin
        if (ack_in) fetch_pc <= fetch_pc + RV'(4);
        if (idone)  head_pc  <= head_pc + RV'(2);
        if (rvalid_in) begin
          if (discard != '0) discard  <= discard - OutW'(1);
          else if (skip_low) skip_low <= 1'b0;
        end
      end
    end
  end

  ifetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .flush  (redir),
    .push_lo(push_lo),
    .push_hi(push_hi),
    .din_lo (make_entry(i_err, i_rdata[15:0])),
    .din_hi (make_entry(i_err, i_rdata[31:16])),
    .pop    (idone),
    .head   (head),
    .count  (count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a behavioural in-order memory and a delivered-parcel log.
module tb_ifetch;

  logic        clk;
  logic        reset;
  logic [15:0] ins;
  logic [31:0] ins_pc;
  logic        ins_err;
  logic        idone;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  logic ack_en    = 1'b1;
  logic rsp_en    = 1'b1;
  logic force_ack = 1'b0;

  logic [31:0] mq[$];
  logic [31:0] req_log[$];

  typedef struct {
    logic [31:0] pc;
    logic [15:0] ins;
    logic        err;
    int unsigned cyc;
  } parcel_t;
  parcel_t got[$];

  ifetch #(
    .RV      (32),
    .RESET_PC(32'h100),
    .DEPTH   (4),
    .MAX_OUT (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_err    (ins_err),
    .idone      (idone),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_err      (i_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default word content makes each parcel equal to the low 16 bits of its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    if (a == 32'h100) return 32'h0002_0001;
    if (a == 32'h204) return 32'hBEEF_1234;
    lo = a[15:0];
    return {lo + 16'd2, lo};
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return a == 32'h600;
  endfunction

  function automatic logic [15:0] exp_ins(input logic [31:0] pc);
    logic [31:0] w;
    if (is_err({pc[31:2], 2'b00})) return 16'h0000;
    w = mem_word({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic parcel_t got_at(input int i);
    parcel_t p;
    p.pc  = 'x;
    p.ins = 'x;
    p.err = 1'bx;
    p.cyc = 0;
    if (i < got.size()) p = got[i];
    return p;
  endfunction

  // Memory: acks at the negedge, answers in order at least one cycle after the ack.
  initial begin
    logic [31:0] a;
    i_ack = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      i_ack = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_err = 1'b0;
      if (reset) begin
        mq.delete();
      end else begin
        if (rsp_en && mq.size() > 0) begin
          a = mq.pop_front();
          i_rvalid = 1'b1;
          if (is_err(a)) begin
            i_err   = 1'b1;
            i_rdata = 32'hDEAD_BEEF;
          end else begin
            i_rdata = mem_word(a);
          end
        end
        if ((i_req && ack_en) || force_ack) begin
          i_ack = 1'b1;
          mq.push_back(i_addr);
          req_log.push_back(i_addr);
        end
      end
    end
  end

  // Every delivered parcel must carry the data of the word at its own pc.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && idone) begin
      got.push_back('{ins_pc, ins, ins_err, cyc});
      checks++;
      if (ins !== exp_ins(ins_pc) || ins_err !== is_err({ins_pc[31:2], 2'b00})) begin
        failures++;
        $display("FAIL stale_parcel pc=%h got ins=%h err=%b want ins=%h err=%b",
                 ins_pc, ins, ins_err, exp_ins(ins_pc), is_err({ins_pc[31:2], 2'b00}));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
    got.delete();
  endtask

  task automatic wait_parcels(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (got.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got %0d parcels want %0d", name, got.size(), n);
    end
  endtask

  task automatic drain_mem();
    int k = 0;
    while (mq.size() > 0 && k < 50) begin
      tick();
      k++;
    end
    tick(2);
  endtask

  task automatic check_parcel(input int i, input logic [31:0] pc, input logic [15:0] v,
                              input logic err, input string name);
    parcel_t p;
    p = got_at(i);
    checks++;
    if (p.pc !== pc || p.ins !== v || p.err !== err) begin
      failures++;
      $display("FAIL %s got pc=%h ins=%h err=%b want pc=%h ins=%h err=%b",
               name, p.pc, p.ins, p.err, pc, v, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(3);
    @(negedge clk); #1;
    checks++;
    if (idone !== 1'b0 || i_req !== 1'b0 || ins !== 16'h0 || ins_pc !== 32'h100 ||
        ins_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got idone=%b i_req=%b ins=%h pc=%h err=%b want 0 0 0000 100 0",
               idone, i_req, ins, ins_pc, ins_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    got.delete();
    @(negedge clk); #1;
    checks++;
    if (i_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_cycle_req got %b want 0", i_req);
    end
    @(negedge clk); #1;
    checks++;
    if (i_req !== 1'b1 || i_addr !== 32'h100) begin
      failures++;
      $display("FAIL reset_first_req got req=%b addr=%h want 1 00000100", i_req, i_addr);
    end
    @(posedge clk); #1;
    wait_parcels(2, "reset");
    check_parcel(0, 32'h100, 16'h0001, 1'b0, "reset_parcel0");
    check_parcel(1, 32'h102, 16'h0002, 1'b0, "reset_parcel1");
  endtask

  task automatic test_redirect_halfword();
    tick(3);
    do_redirect(32'h206);
    req_log.delete();
    wait_parcels(2, "halfword");
    check_parcel(0, 32'h206, 16'hBEEF, 1'b0, "halfword_first");
    check_parcel(1, 32'h208, 16'h0208, 1'b0, "halfword_next");
    checks++;
    if (req_log.size() < 2 || req_log[0] !== 32'h204 || req_log[1] !== 32'h208) begin
      failures++;
      $display("FAIL halfword_req_addr got n=%0d first=%h want 00000204 then 00000208",
               req_log.size(), req_log.size() > 0 ? req_log[0] : 32'hx);
    end
  endtask

  task automatic test_discard_inflight();
    int k = 0;
    ack_en = 1'b0;
    do_redirect(32'h380);
    drain_mem();
    rsp_en = 1'b0; ack_en = 1'b1;
    req_log.delete();
    while (req_log.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    ack_en = 1'b0;
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'h380 || req_log[1] !== 32'h384) begin
      failures++;
      $display("FAIL discard_two_acks got n=%0d want 2 acks at 00000380/00000384",
               req_log.size());
    end
    do_redirect(32'h400);
    rsp_en = 1'b1; ack_en = 1'b1;
    wait_parcels(3, "discard");
    check_parcel(0, 32'h400, 16'h0400, 1'b0, "discard_first");
    check_parcel(2, 32'h404, 16'h0404, 1'b0, "discard_third");
  endtask

  task automatic test_stall_full();
    parcel_t p;
    stall = 1'b1;
    do_redirect(32'h500);
    tick(12);
    @(negedge clk); #1;
    checks++;
    if (idone !== 1'b0 || i_req !== 1'b0 || ins !== 16'h0500 || ins_pc !== 32'h500) begin
      failures++;
      $display("FAIL stall_full got idone=%b i_req=%b ins=%h pc=%h want 0 0 0500 00000500",
               idone, i_req, ins, ins_pc);
    end
    tick(5);
    @(negedge clk); #1;
    checks++;
    if (ins !== 16'h0500 || ins_pc !== 32'h500 || i_req !== 1'b0 || got.size() != 0) begin
      failures++;
      $display("FAIL stall_stable got ins=%h pc=%h i_req=%b delivered=%0d want 0500 500 0 0",
               ins, ins_pc, i_req, got.size());
    end
    tick();
    stall = 1'b0;
    wait_parcels(4, "stall_release");
    check_parcel(0, 32'h500, 16'h0500, 1'b0, "stall_p0");
    check_parcel(1, 32'h502, 16'h0502, 1'b0, "stall_p1");
    check_parcel(3, 32'h506, 16'h0506, 1'b0, "stall_p3");
    p = got_at(3);
    checks++;
    if (p.cyc - got_at(0).cyc != 3) begin
      failures++;
      $display("FAIL stall_back_to_back got span=%0d want 3", p.cyc - got_at(0).cyc);
    end
  endtask

  task automatic test_bus_error();
    do_redirect(32'h600);
    wait_parcels(4, "buserr");
    check_parcel(0, 32'h600, 16'h0000, 1'b1, "buserr_p0");
    check_parcel(1, 32'h602, 16'h0000, 1'b1, "buserr_p1");
    check_parcel(2, 32'h604, 16'h0604, 1'b0, "buserr_next0");
    check_parcel(3, 32'h606, 16'h0606, 1'b0, "buserr_next1");
  endtask

  task automatic test_redirect_same_cycle();
    int k = 0;
    ack_en = 1'b0;
    do_redirect(32'h700);
    drain_mem();
    rsp_en = 1'b0; ack_en = 1'b1;
    req_log.delete();
    while (req_log.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    ack_en = 1'b0;
    // Redirect, response for 0x700 and a late ack for 0x704 all in one cycle.
    force_ack = 1'b1; rsp_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h800;
    tick();
    redirect = 1'b0; force_ack = 1'b0; ack_en = 1'b1;
    got.delete();
    checks++;
    if (req_log.size() < 2 || req_log[1] !== 32'h704) begin
      failures++;
      $display("FAIL same_cycle_addr got n=%0d want ack at 00000704", req_log.size());
    end
    wait_parcels(2, "same_cycle");
    check_parcel(0, 32'h800, 16'h0800, 1'b0, "same_cycle_first");
    check_parcel(1, 32'h802, 16'h0802, 1'b0, "same_cycle_next");
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 32'h900;
    tick();
    redirect_pc = 32'hA02;
    tick();
    redirect = 1'b0;
    got.delete();
    wait_parcels(2, "b2b");
    check_parcel(0, 32'hA02, 16'h0A02, 1'b0, "b2b_first");
    check_parcel(1, 32'hA04, 16'h0A04, 1'b0, "b2b_next");
  endtask

  task automatic test_wrap();
    do_redirect(32'hFFFF_FFFC);
    wait_parcels(3, "wrap");
    check_parcel(0, 32'hFFFF_FFFC, 16'hFFFC, 1'b0, "wrap_p0");
    check_parcel(1, 32'hFFFF_FFFE, 16'hFFFE, 1'b0, "wrap_p1");
    check_parcel(2, 32'h0000_0000, 16'h0000, 1'b0, "wrap_p2");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_redirect_halfword();
    test_discard_inflight();
    test_stall_full();
    test_bus_error();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
